// File: rtl/morse_pkg.sv
// Shared definitions for the Morse puzzle controller: FSM encoding, LFSR
// constants and the frequency table used by the display.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        LOAD   = 3'd2,
        PLAY   = 3'd3,
        CHECK  = 3'd4,
        SOLVED = 3'd5
    } morse_state_e;

    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register: bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_C = 16'hACE1;

    localparam int FREQ_COUNT = 16;
    // Frequencies in kHz, indexed by freq_idx
    localparam logic [11:0] FREQ_TABLE_KHZ [FREQ_COUNT] = '{
        12'd3505, 12'd3515, 12'd3522, 12'd3532, 12'd3535, 12'd3542, 12'd3545, 12'd3552,
        12'd3555, 12'd3565, 12'd3572, 12'd3575, 12'd3582, 12'd3592, 12'd3595, 12'd3600
    };

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        lfsr_next = {value[14:0], ^(value & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises an active-low raw push-button and emits a one-cycle pulse
// once a press has been stable for DEBOUNCE_CYCLES; releases are silent.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchroniser, stability counter and press pulse register
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r  <= 1'b1;
            sync2_r  <= 1'b1;
            stable_r <= 1'b1;
            pulse_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            pulse_r <= 1'b0;
            if (sync2_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_MAX) begin
                stable_r <= sync2_r;
                cnt_r    <= {CNT_W{1'b0}};
                pulse_r  <= ~sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press_pulse = pulse_r;

endmodule

// File: rtl/morse_module_ctrl.sv
// Morse puzzle game controller: picks a secret word, commands the blinker,
// tracks the player's frequency selection and judges submissions.
module morse_module_ctrl
    import morse_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          NUM_FREQ        = 16,
    parameter logic [15:0] LFSR_DEFAULT    = LFSR_DEFAULT_C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    input  logic        arm,
    input  logic        btn_left_n,
    input  logic        btn_right_n,
    input  logic        btn_tx_n,
    output logic [15:0] data,
    output logic        set,
    output logic [3:0]  freq_idx,
    output logic        solved,
    output logic        strike,
    output logic [1:0]  strike_count
);

    localparam logic [3:0] FREQ_MAX = 4'(NUM_FREQ - 1);

    morse_state_e state_r, state_s;
    logic [15:0]  lfsr_r;
    logic         arm_d_r;
    logic [3:0]   word_r, word_s;
    logic [3:0]   freq_r, freq_s;
    logic [15:0]  data_r, data_s;
    logic         set_r, set_s;
    logic         solved_r, solved_s;
    logic         strike_r, strike_s;
    logic [1:0]   count_r, count_s;
    logic         left_pulse_s, right_pulse_s, tx_pulse_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk(clk), .reset(reset), .btn_n(btn_left_n), .press_pulse(left_pulse_s)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk(clk), .reset(reset), .btn_n(btn_right_n), .press_pulse(right_pulse_s)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_tx (
        .clk(clk), .reset(reset), .btn_n(btn_tx_n), .press_pulse(tx_pulse_s)
    );

    // Free-running LFSR and arm edge-detect register
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_r  <= (seed == 16'd0) ? LFSR_DEFAULT : seed;
            arm_d_r <= 1'b0;
        end else begin
            lfsr_r  <= lfsr_next(lfsr_r);
            arm_d_r <= arm;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            word_r   <= 4'd0;
            freq_r   <= 4'd0;
            data_r   <= 16'd0;
            set_r    <= 1'b0;
            solved_r <= 1'b0;
            strike_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            state_r  <= state_s;
            word_r   <= word_s;
            freq_r   <= freq_s;
            data_r   <= data_s;
            set_r    <= set_s;
            solved_r <= solved_s;
            strike_r <= strike_s;
            count_r  <= count_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s  = state_r;
        word_s   = word_r;
        freq_s   = freq_r;
        data_s   = data_r;
        set_s    = 1'b0;
        solved_s = solved_r;
        strike_s = 1'b0;
        count_s  = count_r;
        case (state_r)
            IDLE: begin
                if (arm && !arm_d_r) begin
                    state_s = PICK;
                end else begin
                    state_s = IDLE;
                end
            end
            PICK: begin
                word_s  = lfsr_r[3:0];
                freq_s  = 4'd0;
                state_s = LOAD;
            end
            LOAD: begin
                data_s  = {12'd0, word_r} + 16'd1;
                set_s   = 1'b1;
                state_s = PLAY;
            end
            PLAY: begin
                // Submit wins over any scroll pulse arriving on the same cycle
                if (tx_pulse_s) begin
                    state_s = CHECK;
                end else if (left_pulse_s && right_pulse_s) begin
                    freq_s = freq_r;
                end else if (left_pulse_s) begin
                    if (freq_r != 4'd0) begin
                        freq_s = freq_r - 4'd1;
                    end else begin
                        freq_s = freq_r;
                    end
                end else if (right_pulse_s) begin
                    if (freq_r != FREQ_MAX) begin
                        freq_s = freq_r + 4'd1;
                    end else begin
                        freq_s = freq_r;
                    end
                end else begin
                    freq_s = freq_r;
                end
            end
            CHECK: begin
                if (freq_r == word_r) begin
                    solved_s = 1'b1;
                    state_s  = SOLVED;
                end else begin
                    strike_s = 1'b1;
                    count_s  = (count_r == 2'd3) ? 2'd3 : count_r + 2'd1;
                    state_s  = PLAY;
                end
            end
            SOLVED: begin
                state_s = SOLVED;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign data         = data_r;
    assign set          = set_r;
    assign freq_idx     = freq_r;
    assign solved       = solved_r;
    assign strike       = strike_r;
    assign strike_count = count_r;

endmodule

// File: tb/tb_morse_module_ctrl.sv
// Self-checking bench for morse_module_ctrl with a short debounce window.
module tb_morse_module_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] seed = 16'd0;
    logic        arm = 1'b0;
    logic        bl = 1'b1, br = 1'b1, bt = 1'b1;
    logic [15:0] data;
    logic        set;
    logic [3:0]  freq_idx;
    logic        solved;
    logic        strike;
    logic [1:0]  strike_count;

    int checks = 0;
    int failures = 0;
    int strike_seen = 0;
    int set_seen = 0;

    logic [15:0] lfsr_m;
    logic [3:0]  word_exp;
    logic [3:0]  freq_exp;
    logic [1:0]  sc_exp;
    logic [15:0] data_q[$];
    logic [1:0]  strike_q[$];

    morse_module_ctrl #(.DEBOUNCE_CYCLES(DEB), .NUM_FREQ(16), .LFSR_DEFAULT(16'hACE1)) dut (
        .clk(clk), .reset(reset), .seed(seed), .arm(arm),
        .btn_left_n(bl), .btn_right_n(br), .btn_tx_n(bt),
        .data(data), .set(set), .freq_idx(freq_idx), .solved(solved),
        .strike(strike), .strike_count(strike_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference LFSR running alongside the design
    always @(posedge clk) begin
        if (!reset) lfsr_m <= (seed == 16'd0) ? 16'hACE1 : seed;
        else        lfsr_m <= lfsr_step(lfsr_m);
    end

    task automatic do_reset(input logic [15:0] s);
        @(negedge clk);
        seed = s; reset = 1'b0; arm = 1'b0; bl = 1'b1; br = 1'b1; bt = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        freq_exp = 4'd0;
        sc_exp = 2'd0;
    endtask

    task automatic press(input logic l, input logic r, input logic t);
        logic [1:0] exp_sc;
        @(negedge clk);
        bl = ~l; br = ~r; bt = ~t;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 11) begin bl = 1'b1; br = 1'b1; bt = 1'b1; end
            if (strike === 1'b1) begin
                strike_seen++;
                checks++;
                if (strike_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_strike actual=1 required=0");
                end else begin
                    exp_sc = strike_q.pop_front();
                    if (strike_count !== exp_sc) begin
                        failures++;
                        $display("FAIL strike_count actual=%0d required=%0d", strike_count, exp_sc);
                    end
                end
            end
            if (set === 1'b1) set_seen++;
        end
        if (r && !l && !t && freq_exp != 4'd15) freq_exp = freq_exp + 4'd1;
        if (l && !r && !t && freq_exp != 4'd0)  freq_exp = freq_exp - 4'd1;
    endtask

    task automatic goto_freq(input logic [3:0] target);
        for (int i = 0; i < 16; i++) begin
            if (freq_exp < target)      press(1'b0, 1'b1, 1'b0);
            else if (freq_exp > target) press(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic arm_game();
        logic [15:0] exp_d;
        @(negedge clk); arm = 1'b1;
        @(negedge clk);
        word_exp = lfsr_m[3:0];
        data_q.push_back({12'd0, lfsr_m[3:0]} + 16'd1);
        @(negedge clk);
        checks++;
        if (set !== 1'b0) begin failures++; $display("FAIL set_early actual=%0b required=0", set); end
        @(negedge clk);
        exp_d = data_q.pop_front();
        checks++;
        if (set !== 1'b1) begin failures++; $display("FAIL set_pulse actual=%0b required=1", set); end
        checks++;
        if (data !== exp_d) begin failures++; $display("FAIL data actual=%0h required=%0h", data, exp_d); end
        arm = 1'b0;
        @(negedge clk);
        checks++;
        if (set !== 1'b0 || dut.state_r !== 3'd3) begin
            failures++;
            $display("FAIL set_after actual=%0b/%0d required=0/3", set, dut.state_r);
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset(16'd0);
        checks++;
        if (dut.lfsr_r !== 16'hACE1) begin failures++; $display("FAIL lfsr_seed actual=%0h required=ace1", dut.lfsr_r); end
        checks++;
        if ({data, set, freq_idx, solved, strike, strike_count} !== 25'd0 || dut.state_r !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%0h/%0b/%0d/%0b/%0b/%0d required=0", data, set, freq_idx, solved, strike, strike_count);
        end
        @(negedge clk);
        checks++;
        if (dut.lfsr_r !== lfsr_step(16'hACE1)) begin failures++; $display("FAIL lfsr_step actual=%0h required=%0h", dut.lfsr_r, lfsr_step(16'hACE1)); end
        n = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (set === 1'b1) n++; end
        checks++;
        if (n != 0) begin failures++; $display("FAIL idle_set actual=%0d required=0", n); end
        checks++;
        if (dut.lfsr_r !== lfsr_m) begin failures++; $display("FAIL lfsr_track actual=%0h required=%0h", dut.lfsr_r, lfsr_m); end
    endtask

    task automatic test_arm();
        int n;
        do_reset(16'h0001);
        repeat (2) @(negedge clk);
        arm_game();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            arm = (i >= 2 && i < 5);
            if (set === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin failures++; $display("FAIL rearm_set actual=%0d required=0", n); end
    endtask

    task automatic test_scroll();
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, 1'b0);
        checks++;
        if (freq_idx !== 4'd3) begin failures++; $display("FAIL right_3 actual=%0d required=3", freq_idx); end
        for (int i = 0; i < 20; i++) press(1'b0, 1'b1, 1'b0);
        checks++;
        if (freq_idx !== 4'd15) begin failures++; $display("FAIL right_sat actual=%0d required=15", freq_idx); end
        for (int i = 0; i < 20; i++) press(1'b1, 1'b0, 1'b0);
        checks++;
        if (freq_idx !== 4'd0) begin failures++; $display("FAIL left_sat actual=%0d required=0", freq_idx); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (freq_idx !== 4'd1) begin failures++; $display("FAIL both_lr actual=%0d required=1", freq_idx); end
    endtask

    task automatic test_submit();
        logic [15:0] data_hold;
        if (word_exp == freq_exp) press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            sc_exp = (sc_exp == 2'd3) ? 2'd3 : sc_exp + 2'd1;
            strike_q.push_back(sc_exp);
            strike_seen = 0;
            press(1'b0, 1'b0, 1'b1);
            checks++;
            if (strike_seen != 1) begin failures++; $display("FAIL strike_pulse actual=%0d required=1", strike_seen); end
            checks++;
            if (dut.state_r !== 3'd3 || solved !== 1'b0) begin
                failures++;
                $display("FAIL after_wrong actual=%0d/%0b required=3/0", dut.state_r, solved);
            end
        end
        checks++;
        if (strike_count !== 2'd3) begin failures++; $display("FAIL strike_sat actual=%0d required=3", strike_count); end
        data_hold = {12'd0, word_exp} + 16'd1;
        goto_freq(word_exp);
        strike_seen = 0;
        set_seen = 0;
        press(1'b0, 1'b0, 1'b1);
        checks++;
        if (solved !== 1'b1 || dut.state_r !== 3'd5 || strike_seen != 0) begin
            failures++;
            $display("FAIL solve actual=%0b/%0d/%0d required=1/5/0", solved, dut.state_r, strike_seen);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        @(negedge clk); arm = 1'b1;
        repeat (4) @(negedge clk);
        arm = 1'b0;
        checks++;
        if (freq_idx !== word_exp || solved !== 1'b1 || data !== data_hold || strike_seen != 0 || set_seen != 0) begin
            failures++;
            $display("FAIL solved_hold actual=%0d/%0b/%0h/%0d/%0d required=%0d/1/%0h/0/0",
                     freq_idx, solved, data, strike_seen, set_seen, word_exp, data_hold);
        end
    endtask

    task automatic test_bounce();
        do_reset(16'h1234);
        repeat (2) @(negedge clk);
        arm_game();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            br = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk); br = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (freq_idx !== 4'd1) begin failures++; $display("FAIL bounce_press actual=%0d required=1", freq_idx); end
        br = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (freq_idx !== 4'd1) begin failures++; $display("FAIL bounce_release actual=%0d required=1", freq_idx); end
        freq_exp = 4'd1;
    endtask

    task automatic test_reset_mid();
        if (word_exp == freq_exp) press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            sc_exp = sc_exp + 2'd1;
            strike_q.push_back(sc_exp);
            press(1'b0, 1'b0, 1'b1);
        end
        goto_freq(4'd7);
        checks++;
        if (freq_idx !== 4'd7 || strike_count !== 2'd2) begin
            failures++;
            $display("FAIL pre_reset actual=%0d/%0d required=7/2", freq_idx, strike_count);
        end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({data, set, freq_idx, solved, strike, strike_count} !== 25'd0 || dut.state_r !== 3'd0) begin
            failures++;
            $display("FAIL mid_reset actual=%0h/%0d/%0d/%0d required=0/0/0/0", data, freq_idx, strike_count, dut.state_r);
        end
        reset = 1'b1;
        checks++;
        if (strike_q.size() != 0) begin failures++; $display("FAIL strike_queue actual=%0d required=0", strike_q.size()); end
    endtask

    initial begin
        test_reset();
        test_arm();
        test_scroll();
        test_submit();
        test_bounce();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/morse_module_ctrl.md
Name: morse_module_ctrl

Overview:
- Game-logic controller for the Morse puzzle. It sits directly upstream of the Morse LED blinker and drives that blinker's data and set inputs.
- On arm it picks a secret word index from a free-running LFSR and commands the blinker to start that word's sequence.
- The player scrolls a frequency index with left/right buttons and submits with transmit. The block compares the submission to the secret, then reports solved or a strike.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a raw button must be stable before a press is accepted (10 ms at 50 MHz; benches use 4).
- NUM_FREQ, 16, number of selectable frequencies; freq_idx range is 0..NUM_FREQ-1.
- LFSR_DEFAULT, 16'hACE1, LFSR load value used when seed is zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; shared with the blinker.
- seed  in  16  LFSR load value, sampled while reset is low.
- arm  in  1  level; a rising edge (registered compare) starts a game.
- btn_left_n  in  1  raw push-button, active-low, asynchronous.
- btn_right_n  in  1  raw push-button, active-low, asynchronous.
- btn_tx_n  in  1  raw push-button, active-low, asynchronous.
- data  out  16  word code to the blinker: {12'b0, word_idx} + 1, range 1..16.
- set  out  1  one-cycle load strobe to the blinker.
- freq_idx  out  4  currently selected frequency.
- solved  out  1  level; high once the module is defused.
- strike  out  1  one-cycle pulse per wrong submission.
- strike_count  out  2  number of wrong submissions, saturating at 3.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: all state is sampled at posedge clk while reset==0.
- Reset values: data=0, set=0, freq_idx=0, solved=0, strike=0, strike_count=0, state=IDLE, arm_d=0. LFSR loads seed, or LFSR_DEFAULT if seed==0.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left. It advances every cycle out of reset in every state and never reaches all-zero.
- Buttons: each passes through button_debounce, which produces a 1-cycle press pulse. Pulse latency from a stable press is 2 sync cycles + DEBOUNCE_CYCLES + 1.
- States and transitions:
  - IDLE: set=0. On arm & ~arm_d, go to PICK.
  - PICK: word_idx <= lfsr[3:0], freq_idx <= 0. Next state is LOAD.
  - LOAD: data <= word_idx+1 and set=1 for exactly this one cycle. Next state is PLAY.
  - PLAY: if tx pulse, go to CHECK; tx has priority and a simultaneous left/right pulse is dropped. Otherwise left and right together means no change. Left alone gives freq_idx-1, saturating at 0. Right alone gives freq_idx+1, saturating at NUM_FREQ-1.
  - CHECK: if freq_idx==word_idx, solved<=1 and go to SOLVED. Otherwise strike=1 for one cycle, strike_count<=min(count+1,3), and return to PLAY.
  - SOLVED: terminal until reset. Buttons and arm are ignored; data holds; set=0.
- CHECK never re-pulses set, so the blinker keeps looping the same word.
- arm high in any state other than IDLE is ignored. Re-arming requires reset.
- data holds its value from LOAD until reset.
- Reset mid-operation (any state): the next edge returns every output to its reset value. The blinker resets on the same edge.
- End-to-end latency: the arm rising edge to the set pulse is 3 clk (arm_d compare, PICK, LOAD).

Decomposition:
- Shared package morse_pkg holds:
  - the state encodings IDLE=0, PICK=1, LOAD=2, PLAY=3, CHECK=4, SOLVED=5;
  - the LFSR tap constant and LFSR_DEFAULT;
  - the frequency table constants, for later display use.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES), instantiated 3 times:
  - 2-FF synchronizer feeding a stability counter;
  - outputs press_pulse on the stable 1->0 transition of the raw input only;
  - releases produce no pulse.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset low 3 cycles with seed=0, then release -> all outputs 0, LFSR == 16'hACE1 on the first cycle after release, set never asserts.
2. seed=16'h0001, arm rises -> set high exactly 1 cycle, 3 clk after the edge, data==lfsr[3:0]+1 as sampled in PICK; a second arm pulse produces no set.
3. Freq scrolling in PLAY:
   - 3 clean right presses -> freq_idx=3;
   - 20 further right presses -> freq_idx=15;
   - 20 left presses -> freq_idx=0;
   - simultaneous left+right pulse -> freq_idx unchanged.
4. Submissions:
   - tx with freq_idx!=word_idx -> strike high 1 cycle, strike_count=1, state PLAY;
   - 4 wrong tx total -> strike_count=3 (saturated);
   - tx with the correct idx -> solved=1 permanently, later buttons change nothing.
5. btn_right_n toggling every 2 cycles for 20 cycles, then held low 10 cycles -> exactly one pulse and freq_idx +1; the release produces no pulse.
6. Reset low during PLAY with freq_idx=7, strike_count=2 -> next edge gives freq_idx=0, strike_count=0, data=0, state IDLE.
